// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Holds the op encodings, the FSM state type, the default operand width and
// a helper that sizes the iteration counter.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Counter must hold the value WIDTH, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   acc_i  / acc_o  : upper half accumulator (partial product / partial remainder)
//   qreg_i / qreg_o : lower half register (multiplier bits / dividend->quotient bits)
//   opnd_i          : multiplicand magnitude or divisor magnitude
//   div_i           : 1 = restoring shift-subtract, 0 = shift-add
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] qreg_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] qreg_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // then shift {carry, acc, qreg} right by one.
        mul_sum   = {1'b0, acc_i} + (qreg_i[0] ? {1'b0, opnd_i} : '0);

        // Divide: shift the next dividend bit into the remainder and try a subtract.
        div_shift = {acc_i, qreg_i[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_i});
        div_diff  = div_shift - {1'b0, opnd_i};

        if (div_i) begin
            // Remainder stays below the divisor, so it always fits in WIDTH bits.
            acc_o  = div_ge ? WIDTH'(div_diff) : WIDTH'(div_shift);
            qreg_o = {qreg_i[WIDTH-2:0], div_ge};
        end else begin
            acc_o  = mul_sum[WIDTH:1];
            qreg_o = {mul_sum[0], qreg_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU over WIDTH radix-2 iterations plus one sign-fix
// cycle, and services MTHI/MTLO writes while idle.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start, op, A, B : launch an operation (sampled only in IDLE)
//   flush           : abort an in-flight operation, HI/LO untouched
//   mthi, mtlo      : write HI / LO from A while idle
//   busy            : operation in flight (hazard stall)
//   done            : one-cycle pulse when HI/LO carry a new result
//   hi, lo          : HI and LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   qreg_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div_q;
    logic               neg_q_q;    // negate product / quotient
    logic               neg_r_q;    // negate remainder
    logic               div0_q;
    logic               busy_q;
    logic               done_q;

    // Operand decode and magnitude conversion for the launch cycle.
    logic             op_signed;
    logic             op_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        op_signed = 1'b0;
        op_div    = 1'b0;
        case (op)
            OP_MULT:  op_signed = 1'b1;
            OP_MULTU: op_signed = 1'b0;
            OP_DIV: begin
                op_signed = 1'b1;
                op_div    = 1'b1;
            end
            OP_DIVU:  op_div    = 1'b1;
            default:  op_div    = 1'b0;
        endcase
        sign_a = op_signed & A[WIDTH-1];
        sign_b = op_signed & B[WIDTH-1];
        mag_a  = sign_a ? (~A + WIDTH'(1)) : A;
        mag_b  = sign_b ? (~B + WIDTH'(1)) : B;
    end

    // Single iteration datapath.
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_qreg;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i  (acc_q),
        .qreg_i (qreg_q),
        .opnd_i (opnd_q),
        .div_i  (is_div_q),
        .acc_o  (step_acc),
        .qreg_o (step_qreg)
    );

    // Sign correction applied on the FIX edge.
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    always_comb begin
        prod_mag = {acc_q, qreg_q};
        prod_fix = neg_q_q ? (~prod_mag + PW'(1)) : prod_mag;
        quo_fix  = neg_q_q ? (~qreg_q + WIDTH'(1)) : qreg_q;
        rem_fix  = neg_r_q ? (~acc_q + WIDTH'(1)) : acc_q;
        if (is_div_q) begin
            // Divide by zero yields all-ones quotient regardless of sign; the
            // remainder path already reconstructs the original dividend.
            fix_hi = rem_fix;
            fix_lo = div0_q ? '1 : quo_fix;
        end else begin
            fix_hi = prod_fix[PW-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM, iteration counter and architectural registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            qreg_q   <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // start always wins over mt*; flush suppresses the launch
                        if (!flush) begin
                            state_q  <= CALC;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            is_div_q <= op_div;
                            qreg_q   <= op_div ? mag_a : mag_b;
                            opnd_q   <= op_div ? mag_b : mag_a;
                            neg_q_q  <= sign_a ^ sign_b;
                            neg_r_q  <= sign_a;
                            div0_q   <= op_div & (B == '0);
                        end
                    end else begin
                        if (mthi) hi_q <= A;
                        if (mtlo) lo_q <= A;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q  <= step_acc;
                        qreg_q <= step_qreg;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed operations with hand-computed
// HI/LO results pushed to a scoreboard, checked by an independent monitor on
// each done pulse, plus direct checks of reset, mt*, flush and latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         flush = 1'b0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t exp_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            check("done_while_busy", {31'b0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with hi=0x%h lo=0x%h expected no pulse", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input string name,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        if (push) begin
            e.name = name; e.hi = eh; e.lo = el;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done, counting busy cycles since the launch edge.
    task automatic wait_done(input string name, input int pre_busy);
        int nb;
        int cyc;
        bit seen;
        nb = pre_busy; cyc = pre_busy; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) nb++;
        end
        check({name, "_done_seen"}, W'(seen), 32'd1);
        check({name, "_busy_cycles"}, W'(nb), 32'd33);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
        launch(o, a, b, 1'b1, name, eh, el);
        wait_done(name, 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        // Arithmetic vectors
        run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, "mult_neg3x7",   32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max",     32'hFFFFFFFE, 32'h00000001);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, "div_neg7by2",   32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(OP_DIVU,  32'd100,      32'd7,        "divu_100by7",   32'd2,        32'd14);
        run_op(OP_DIVU,  32'h12345678, 32'h00000000, "divu_by0",      32'h12345678, 32'hFFFFFFFF);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_overflow",  32'h00000000, 32'h80000000);
        run_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, "div_7byneg2",   32'h00000001, 32'hFFFFFFFD);
        run_op(OP_MULT,  32'h80000000, 32'h80000000, "mult_minsq",    32'h40000000, 32'h00000000);
        run_op(OP_DIV,   32'hFFFFFFFB, 32'h00000000, "div_neg5by0",   32'hFFFFFFFB, 32'hFFFFFFFF);

        // mthi then mtlo
        @(posedge clk); #1;
        mthi = 1'b1; A = 32'hAAAA0000;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_hi", hi, 32'hAAAA0000);
        mtlo = 1'b1; A = 32'h00005555;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h00005555);
        check("mtlo_hi_kept", hi, 32'hAAAA0000);

        // Flush mid-operation
        launch(OP_MULT, 32'd3, 32'd4, 1'b0, "", '0, '0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_drop", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_hi_kept", hi, 32'hAAAA0000);
        check("flush_lo_kept", lo, 32'h00005555);

        // mthi and a stray start while busy are both ignored
        launch(OP_DIVU, 32'd100, 32'd7, 1'b1, "divu_busy_mthi", 32'd2, 32'd14);
        mthi = 1'b1; start = 1'b1; op = OP_MULT; A = 32'hDEADBEEF; B = 32'h0;
        @(posedge clk); #1;
        mthi = 1'b0; start = 1'b0;
        check("mthi_busy_ignored", hi, 32'hAAAA0000);
        wait_done("divu_busy_mthi", 1);

        // flush together with start in IDLE suppresses the launch
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_start_idle_lo", lo, 32'd14);

        // mthi and mtlo in the same cycle
        @(posedge clk); #1;
        mthi = 1'b1; mtlo = 1'b1; A = 32'h13579BDF;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", hi, 32'h13579BDF);
        check("mt_both_lo", lo, 32'h13579BDF);

        // start wins over a simultaneous mthi/mtlo
        @(posedge clk); #1;
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = OP_DIV; A = 32'd7; B = 32'hFFFFFFFE;
        begin
            exp_t e;
            e.name = "div_start_wins"; e.hi = 32'h00000001; e.lo = 32'hFFFFFFFD;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_wins_hi", hi, 32'h13579BDF);
        check("start_wins_lo", lo, 32'h13579BDF);
        wait_done("div_start_wins", 0);

        // Reset in the middle of CALC
        launch(OP_MULT, 32'd5, 32'd6, 1'b0, "", '0, '0);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        run_op(OP_MULT, 32'h12345678, 32'h00000010, "mult_after_rst", 32'h00000001, 32'h23456780);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit that sits beside the single-cycle EX-stage ALU in the pipeline.
- Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers and services MTHI/MTLO writes.
- Provides HI/LO read data for MFHI/MFLO.
- Hazard logic uses `busy` to stall.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  in  WIDTH  rs operand (multiplicand / dividend)
B  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort in-flight operation (branch/exception squash)
mthi  in  1  write HI from A
mtlo  in  1  write LO from A
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO hold the new result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, hi=lo=0, busy=0, done=0, counter=0. Takes effect mid-operation; the partial result is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch operands and convert to magnitudes for signed ops.
  - Latch result-sign flags: quotient sign = sA^sB; remainder sign = sA.
  - Clear the accumulator and go to CALC with counter=0.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments; after WIDTH steps (edge E32) go to FIX.
- FIX (edge E33):
  - Apply sign correction (two's-complement negate where a flag is set).
  - Write hi/lo, set done=1 for exactly one cycle, return to IDLE.
- Latency:
  - busy=1 in the cycles after E0 through E33 (33 cycles).
  - done=1 in the cycle after E33; start→done = 33 cycles.
- Multiply result: {hi,lo} = full 2*WIDTH product, signed or unsigned per op.
- Divide result: lo = quotient, hi = remainder.
  - Quotient truncates toward zero.
  - Remainder sign equals the dividend sign.
- Divide by zero (B=0), either DIV or DIVU:
  - lo=all-ones, hi=A.
  - Normal latency and done pulse; no exception.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored (the stall guarantees this does not occur; RTL must still not corrupt the operation).
- mthi/mtlo:
  - In IDLE with start=0: write on the next edge; both may be asserted together.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the mt* writes are discarded.
- flush:
  - While busy: return to IDLE next edge, hi/lo unchanged, no done pulse.
  - flush with start in IDLE: start is ignored.
  - flush in IDLE otherwise: no effect.
- hi/lo change only on a FIX edge, an accepted mthi/mtlo, or reset.
- done is never asserted when busy=1.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU (2-bit);
  - state enum IDLE/CALC/FIX;
  - WIDTH default and counter width clog2(WIDTH)+1.
- One natural sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: accumulator, operand register, mode.
  - Outputs: next accumulator and next quotient/product bits.
  - The top level holds the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 → after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIVU A=100, B=7 → lo=14, hi=2.
- DIVU A=0x12345678, B=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Hold-off and priority, in sequence:
  - mthi A=0xAAAA0000, then mtlo A=0x5555 → hi/lo updated next edge.
  - start MULT 3*4; assert flush at cycle 10 → busy drops next cycle, no done, hi/lo still 0xAAAA0000/0x5555.
  - mthi during a subsequent busy op is ignored.
- Reset mid-CALC (rst_n=0 at cycle 15 of an op) → next edge hi=lo=0, busy=0, done=0. A fresh start then completes normally in 33 cycles.
